// File: rtl/fifo_async_pkg.sv
// fifo_async_pkg: shared sizing helper and memory-style names for the FWFT FIFO
package fifo_async_pkg;
  localparam MEM_AUTO = "auto";
  localparam MEM_DISTRIBUTED = "distributed";
  localparam MEM_BLOCK = "block";
  function automatic int bits(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fifo_async_fwft_if.sv
// fifo_async_fwft_if: write/read handshake, status and error bundle of the FWFT FIFO
interface fifo_async_fwft_if
  import fifo_async_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IN_W = 1,
  parameter int OUT_W = 1,
  parameter int CW = bits(DEPTH * IN_W / OUT_W)
);
  logic [IN_W-1:0] din;
  logic wr_en;
  logic full;
  logic [OUT_W-1:0] dout;
  logic rd_en;
  logic empty;
  logic [CW-1:0] rd_data_count;
  logic wr_rst_busy;
  logic rd_rst_busy;
  logic overflow;
  logic underflow;
  modport master (
    output din, wr_en, rd_en,
    input full, dout, empty, rd_data_count, wr_rst_busy, rd_rst_busy, overflow, underflow
  );
  modport slave (
    input din, wr_en, rd_en,
    output full, dout, empty, rd_data_count, wr_rst_busy, rd_rst_busy, overflow, underflow
  );
endinterface

// File: rtl/fifo_sdp_ram.sv
// fifo_sdp_ram: simple dual-port unit RAM; sync write of WR units, async read of RR units
module fifo_sdp_ram
  import fifo_async_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int UW = 1,
  parameter int WR = 1,
  parameter int RR = 1,
  parameter MEMTYPE = MEM_AUTO,
  localparam int AW = $clog2(DEPTH),
  localparam int WA = $clog2(DEPTH / WR),
  localparam int RA = $clog2(DEPTH / RR)
) (
  input  logic clk,
  input  logic we,
  input  logic [WA-1:0] waddr,
  input  logic [WR*UW-1:0] wdata,
  input  logic [RA-1:0] raddr,
  output logic [RR*UW-1:0] rdata
);
  if (MEMTYPE != MEM_AUTO && MEMTYPE != MEM_DISTRIBUTED && MEMTYPE != MEM_BLOCK) begin : g_bad_memtype
    $error("fifo_sdp_ram: unsupported MEMTYPE");
  end
  (* ram_style = MEMTYPE *) logic [UW-1:0] mem [DEPTH];
  // lowest unit address of a word holds its MSB slice, so it is read out first
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < WR; i++) mem[AW'(waddr * WR + i)] <= wdata[(WR-1-i)*UW +: UW];
  always_comb begin
    rdata = '0;
    for (int i = 0; i < RR; i++) rdata[(RR-1-i)*UW +: UW] = mem[AW'(raddr * RR + i)];
  end
endmodule

// File: rtl/fifo_async_fwft.sv
// fifo_async_fwft: single-clock first-word-fall-through FIFO with width conversion and reset-busy
module fifo_async_fwft
  import fifo_async_pkg::*;
#(
  parameter int FIFO_WRITE_DEPTH = 32,
  parameter int WRITE_DATA_WIDTH = 1,
  parameter int READ_DATA_WIDTH = 1,
  parameter FIFO_MEMORY_TYPE = MEM_AUTO,
  parameter int RD_DATA_COUNT_WIDTH = bits(FIFO_WRITE_DEPTH * WRITE_DATA_WIDTH / READ_DATA_WIDTH),
  parameter logic [READ_DATA_WIDTH-1:0] DOUT_RESET_VALUE = '0,
  parameter int RST_BUSY_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  fifo_async_fwft_if.slave bus
);
  localparam int UW = WRITE_DATA_WIDTH < READ_DATA_WIDTH ? WRITE_DATA_WIDTH : READ_DATA_WIDTH;
  localparam int RIN = WRITE_DATA_WIDTH / UW;
  localparam int ROUT = READ_DATA_WIDTH / UW;
  localparam int UNITS = FIFO_WRITE_DEPTH * RIN;
  localparam int AW = $clog2(UNITS);
  localparam int PW = AW + 1;
  localparam int LIN = $clog2(RIN);
  localparam int LOUT = $clog2(ROUT);
  localparam int BW = bits(RST_BUSY_CYCLES + 1);
  if (RIN * UW != WRITE_DATA_WIDTH || ROUT * UW != READ_DATA_WIDTH || 2**LIN != RIN || 2**LOUT != ROUT) begin : g_bad_ratio
    $error("fifo_async_fwft: width ratio must be a power of two");
  end
  // pointers count storage units and carry one wrap bit above the address
  logic [PW-1:0] wp, rp, occ, occ_n;
  logic [BW-1:0] cnt;
  logic busy, busy_n, wr_acc, rd_acc;
  logic [READ_DATA_WIDTH-1:0] rdata;
  always_comb begin
    busy = cnt != '0;
    busy_n = cnt > BW'(1);
    wr_acc = bus.wr_en && !bus.full && !busy;
    rd_acc = bus.rd_en && !bus.empty && !busy;
    occ = wp - rp;
    occ_n = occ + (wr_acc ? PW'(RIN) : '0) - (rd_acc ? PW'(ROUT) : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= BW'(RST_BUSY_CYCLES);
      bus.full <= 1'b1;
      bus.empty <= 1'b1;
      bus.rd_data_count <= '0;
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      wp <= wr_acc ? wp + PW'(RIN) : wp;
      rp <= rd_acc ? rp + PW'(ROUT) : rp;
      cnt <= busy ? cnt - 1'b1 : cnt;
      bus.full <= busy_n || occ_n > PW'(UNITS - RIN);
      bus.empty <= busy_n || occ_n < PW'(ROUT);
      bus.rd_data_count <= RD_DATA_COUNT_WIDTH'(occ_n >> LOUT);
      bus.overflow <= bus.wr_en && bus.full;
      bus.underflow <= bus.rd_en && bus.empty;
    end
  assign bus.wr_rst_busy = busy;
  assign bus.rd_rst_busy = busy;
  assign bus.dout = bus.empty ? DOUT_RESET_VALUE : rdata;
  fifo_sdp_ram #(
    .DEPTH(UNITS), .UW(UW), .WR(RIN), .RR(ROUT), .MEMTYPE(FIFO_MEMORY_TYPE)
  ) ram (
    .clk(clk),
    .we(wr_acc),
    .waddr(wp[AW-1:LIN]),
    .wdata(bus.din),
    .raddr(rp[AW-1:LOUT]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_fifo_async_fwft.sv
// tb_fifo_async_fwft: three width configurations checked against a bit-queue model every cycle
module tb_fifo_async_fwft;
  localparam int N = 3;
  localparam int DEP = 16;
  localparam int IWS [N] = '{8, 8, 32};
  localparam int OWS [N] = '{8, 32, 8};
  localparam int RBC = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en [N];
  logic rd_en [N];
  logic [31:0] din [N];
  logic d_full [N], d_empty [N], d_ovf [N], d_unf [N], d_wbusy [N], d_rbusy [N];
  logic [31:0] d_dout [N];
  logic [7:0] d_cnt [N];
  bit q [N][$];
  int bcnt = RBC;
  bit m_ovf [N];
  bit m_unf [N];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : c
    localparam int IW = IWS[g];
    localparam int OW = OWS[g];
    fifo_async_fwft_if #(.DEPTH(DEP), .IN_W(IW), .OUT_W(OW)) bus ();
    fifo_async_fwft #(.FIFO_WRITE_DEPTH(DEP), .WRITE_DATA_WIDTH(IW), .READ_DATA_WIDTH(OW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    assign bus.din = din[g][IW-1:0];
    assign bus.wr_en = wr_en[g];
    assign bus.rd_en = rd_en[g];
    assign d_full[g] = bus.full;
    assign d_empty[g] = bus.empty;
    assign d_ovf[g] = bus.overflow;
    assign d_unf[g] = bus.underflow;
    assign d_wbusy[g] = bus.wr_rst_busy;
    assign d_rbusy[g] = bus.rd_rst_busy;
    assign d_dout[g] = 32'(bus.dout);
    assign d_cnt[g] = 8'(bus.rd_data_count);
  end
  function automatic bit m_full(input int g);
    return bcnt != 0 || DEP * IWS[g] - q[g].size() < IWS[g];
  endfunction
  function automatic bit m_empty(input int g);
    return bcnt != 0 || q[g].size() < OWS[g];
  endfunction
  function automatic logic [31:0] m_dout(input int g);
    logic [31:0] v = '0;
    if (!m_empty(g)) for (int i = 0; i < OWS[g]; i++) v = {v[30:0], q[g][i]};
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask
  // model: stored bits in write order; flags follow from the bit count after each edge
  always @(posedge clk or negedge rst_n) begin
    bit f, e;
    if (!rst_n) begin
      bcnt = RBC;
      for (int g = 0; g < N; g++) begin
        q[g].delete();
        m_ovf[g] = 1'b0;
        m_unf[g] = 1'b0;
      end
    end else begin
      for (int g = 0; g < N; g++) begin
        f = m_full(g);
        e = m_empty(g);
        m_ovf[g] = wr_en[g] && f;
        m_unf[g] = rd_en[g] && e;
        if (rd_en[g] && !e) repeat (OWS[g]) void'(q[g].pop_front());
        if (wr_en[g] && !f) for (int i = IWS[g] - 1; i >= 0; i--) q[g].push_back(din[g][i]);
      end
      if (bcnt > 0) bcnt--;
    end
  end
  always @(negedge clk)
    for (int g = 0; g < N; g++) begin
      chk($sformatf("full[%0d]", g), 32'(d_full[g]), 32'(m_full(g)));
      chk($sformatf("empty[%0d]", g), 32'(d_empty[g]), 32'(m_empty(g)));
      chk($sformatf("dout[%0d]", g), d_dout[g], m_dout(g));
      chk($sformatf("count[%0d]", g), 32'(d_cnt[g]), q[g].size() / OWS[g]);
      chk($sformatf("overflow[%0d]", g), 32'(d_ovf[g]), 32'(m_ovf[g]));
      chk($sformatf("underflow[%0d]", g), 32'(d_unf[g]), 32'(m_unf[g]));
      chk($sformatf("wr_busy[%0d]", g), 32'(d_wbusy[g]), 32'(bcnt != 0));
      chk($sformatf("rd_busy[%0d]", g), 32'(d_rbusy[g]), 32'(bcnt != 0));
    end
  task automatic cyc(input int g, input bit w, input bit r, input logic [31:0] d = '0);
    wr_en[g] = w;
    rd_en[g] = r;
    din[g] = d;
    @(posedge clk);
    #1;
    wr_en[g] = 1'b0;
    rd_en[g] = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] nb [4];
    nb = '{8'h22, 8'h33, 8'h44, 8'h00};
    for (int g = 0; g < N; g++) begin
      wr_en[g] = 1'b0;
      rd_en[g] = 1'b0;
      din[g] = '0;
    end
    tick();
    chk("rst_empty", 32'(d_empty[0]), 1);
    chk("rst_full", 32'(d_full[0]), 1);
    chk("rst_busy", 32'(d_wbusy[0]), 1);
    chk("rst_count", 32'(d_cnt[0]), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("busy_edge1", 32'(d_rbusy[0]), 1);
    tick();
    chk("busy_edge2", 32'(d_rbusy[0]), 0);
    chk("full_drop", 32'(d_full[0]), 0);
    cyc(0, 0, 1);
    chk("underflow_pulse", 32'(d_unf[0]), 1);
    chk("underflow_empty", 32'(d_empty[0]), 1);
    chk("underflow_dout", d_dout[0], 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 0, 32'(i));
      if (i == 1) chk("fwft_first", d_dout[0], 1);
    end
    chk("full_16", 32'(d_full[0]), 1);
    chk("count_16", 32'(d_cnt[0]), 16);
    cyc(0, 1, 0, 32'h99);
    chk("overflow_17", 32'(d_ovf[0]), 1);
    for (int i = 1; i <= 16; i++) begin
      chk("read_order", d_dout[0], 32'(i));
      cyc(0, 0, 1);
    end
    chk("drained_empty", 32'(d_empty[0]), 1);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 32'(8'h20 + i));
    cyc(0, 1, 1, 32'hEE);
    chk("full_rw_overflow", 32'(d_ovf[0]), 1);
    chk("full_rw_count", 32'(d_cnt[0]), 15);
    chk("full_rw_dout", d_dout[0], 32'h21);
    repeat (15) cyc(0, 0, 1);
    cyc(1, 1, 0, 32'hAA);
    cyc(1, 1, 0, 32'hBB);
    cyc(1, 1, 0, 32'hCC);
    chk("wide_partial_empty", 32'(d_empty[1]), 1);
    cyc(1, 1, 0, 32'hDD);
    chk("wide_dout", d_dout[1], 32'hAABBCCDD);
    chk("wide_count", 32'(d_cnt[1]), 1);
    cyc(1, 0, 1);
    chk("wide_empty_after", 32'(d_empty[1]), 1);
    cyc(2, 1, 0, 32'h11223344);
    chk("narrow_count4", 32'(d_cnt[2]), 4);
    chk("narrow_first", d_dout[2], 32'h11);
    for (int k = 0; k < 4; k++) begin
      cyc(2, 0, 1);
      chk("narrow_next", d_dout[2], 32'(nb[k]));
      chk("narrow_count", 32'(d_cnt[2]), 32'(3 - k));
    end
    for (int i = 0; i < 16; i++) cyc(2, 1, 0, 32'hA0B0C000 + 32'(i));
    chk("narrow_full", 32'(d_full[2]), 1);
    cyc(2, 0, 1);
    chk("narrow_full_one_slice", 32'(d_full[2]), 1);
    repeat (3) cyc(2, 0, 1);
    chk("narrow_full_slot_free", 32'(d_full[2]), 0);
    repeat (60) cyc(2, 0, 1);
    for (int i = 0; i < 60; i++) begin
      for (int g = 0; g < N; g++) begin
        wr_en[g] = ((i + g) % 3) != 2;
        rd_en[g] = ((i * (g + 1)) % 4) != 0;
        din[g] = 32'(i * 32'h01030507 + g * 17);
      end
      tick();
    end
    for (int g = 0; g < N; g++) begin
      wr_en[g] = 1'b0;
      rd_en[g] = 1'b0;
    end
    repeat (20) cyc(0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 32'(8'h50 + i));
    rst_n = 1'b0;
    #1;
    chk("midrst_empty", 32'(d_empty[0]), 1);
    chk("midrst_count", 32'(d_cnt[0]), 0);
    chk("midrst_busy", 32'(d_wbusy[0]), 1);
    chk("midrst_dout", d_dout[0], 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_busy_edge1", 32'(d_wbusy[0]), 1);
    tick();
    chk("midrst_busy_edge2", 32'(d_wbusy[0]), 0);
    cyc(0, 1, 0, 32'h77);
    chk("no_stale_dout", d_dout[0], 32'h77);
    chk("no_stale_count", 32'(d_cnt[0]), 1);
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
